// File: rtl/word_pkg.sv
// Shared types and constants for the 8-bit word-bus receive path.
package word_pkg;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W          = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Byte lane within the assembled word for arrival index k.
    function automatic logic [IDX_W-1:0] byte_slot(input logic [IDX_W-1:0] k, input logic msb_first);
        return msb_first ? (LAST_IDX - k) : k;
    endfunction
endpackage

// File: rtl/word_assembler_if.sv
// Byte-in / word-out handshake bundle for the word assembler.
interface word_assembler_if;
    import word_pkg::*;

    logic [BYTE_W-1:0] word_in;
    logic              word_valid;
    logic              word_sof;
    logic              word_ready;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output word_in, word_valid, word_sof, data_ready,
        input  word_ready, data_out, data_valid
    );

    modport slave (
        input  word_in, word_valid, word_sof, data_ready,
        output word_ready, data_out, data_valid
    );
endinterface

// File: rtl/word_collector.sv
// Byte index and staging register; places each byte by arrival order.
module word_collector
    import word_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              accept,
    input  logic              sof,
    output logic [IDX_W-1:0]  idx,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);
    logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] stage;
    logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] word_bytes;

    // The final byte bypasses staging so the word is ready on the accepting edge.
    always_comb begin
        word_bytes = stage;
        word_bytes[byte_slot(idx, MSB_FIRST)] = byte_in;
    end

    assign word      = word_bytes;
    assign word_done = accept && !sof && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx   <= '0;
            stage <= '0;
        end else if (accept) begin
            if (sof) begin
                stage <= '0;
                stage[byte_slot('0, MSB_FIRST)] <= byte_in;
                idx   <= IDX_W'(1);
            end else if (idx != '0) begin
                // idx wraps 3 -> 0 when the word completes.
                stage[byte_slot(idx, MSB_FIRST)] <= byte_in;
                idx   <= idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/word_assembler.sv
// Reassembles 32-bit words from a framed byte stream; flags framing errors.
module word_assembler
    import word_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    word_assembler_if.slave  bus,
    output logic             error,
    output logic [CNT_W-1:0] word_count
);
    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              word_done;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] data_q;
    logic              valid_q;
    logic              byte_acc;
    logic              out_acc;
    logic              ready;

    // Stall only the closing byte, and only while the previous word is still held.
    assign ready    = reset && !((idx == LAST_IDX) && valid_q && !bus.data_ready);
    assign byte_acc = bus.word_valid && ready;
    assign out_acc  = valid_q && bus.data_ready;

    assign bus.word_ready = ready;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;

    word_collector #(.MSB_FIRST(MSB_FIRST)) u_collector (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (bus.word_in),
        .accept    (byte_acc),
        .sof       (bus.word_sof),
        .idx       (idx),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            error      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            word_count <= '0;
        end else begin
            error <= byte_acc && ((state == IDLE) ? !bus.word_sof : bus.word_sof);
            case (state)
                IDLE:    if (byte_acc && bus.word_sof) state <= COLLECT;
                COLLECT: if (word_done) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (word_done) begin
                data_q     <= word;
                valid_q    <= 1'b1;
                word_count <= word_count + CNT_W'(1);
            end else if (out_acc) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_word_assembler.sv
// Self-checking bench: MSB-first and LSB-first instances driven in lockstep.
module tb_word_assembler;
    logic       clk = 1'b0;
    logic       reset;
    logic       err_m, err_l;
    logic [7:0] cnt_m;
    logic [1:0] cnt_l;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [31:0] q_m[$];
    logic [31:0] q_l[$];

    typedef struct {
        logic [7:0]  b;
        logic        sof;
        logic        err_next;
        logic        done;
        logic [31:0] w_msb;
        logic [31:0] w_lsb;
    } vec_t;
    vec_t tbl[15];

    word_assembler_if bus_m();
    word_assembler_if bus_l();

    word_assembler #(.MSB_FIRST(1'b1), .CNT_W(8)) dut_m (
        .clk(clk), .reset(reset), .bus(bus_m.slave), .error(err_m), .word_count(cnt_m));
    word_assembler #(.MSB_FIRST(1'b0), .CNT_W(2)) dut_l (
        .clk(clk), .reset(reset), .bus(bus_l.slave), .error(err_l), .word_count(cnt_l));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: compare each word as the consumer takes it.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus_m.data_valid && bus_m.data_ready) begin
            if (q_m.size() == 0) check("msb_unexpected_word", bus_m.data_out, 32'hxxxxxxxx);
            else check("msb_word", bus_m.data_out, q_m.pop_front());
        end
        if (reset === 1'b1 && bus_l.data_valid && bus_l.data_ready) begin
            if (q_l.size() == 0) check("lsb_unexpected_word", bus_l.data_out, 32'hxxxxxxxx);
            else check("lsb_word", bus_l.data_out, q_l.pop_front());
        end
    end

    task automatic drive(input logic [7:0] b, input logic sof, input logic v);
        bus_m.word_in = b;  bus_m.word_sof = sof;  bus_m.word_valid = v;
        bus_l.word_in = b;  bus_l.word_sof = sof;  bus_l.word_valid = v;
    endtask

    task automatic set_ready(input logic r);
        bus_m.data_ready = r;
        bus_l.data_ready = r;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_m.word_ready && bus_l.word_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        else begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input logic sof);
        drive(b, sof, 1'b1);
        wait_accept();
    endtask

    task automatic idle_cycles(input int n);
        drive(8'h00, 1'b0, 1'b0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{8'hAA, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{8'hBB, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[2]  = '{8'hCC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[3]  = '{8'hDD, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 32'hDDCCBBAA};
        tbl[4]  = '{8'h11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[5]  = '{8'h22, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[6]  = '{8'h33, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[7]  = '{8'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[8]  = '{8'h55, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[9]  = '{8'h66, 1'b0, 1'b0, 1'b1, 32'h33445566, 32'h66554433};
        tbl[10] = '{8'h77, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[11] = '{8'h01, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[12] = '{8'h02, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[13] = '{8'h03, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[14] = '{8'h04, 1'b0, 1'b0, 1'b1, 32'h01020304, 32'h04030201};

        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0);
        set_ready(1'b1);
        #1;
        check("rst_data_out", bus_m.data_out, 32'h0);
        check("rst_data_valid", {31'd0, bus_m.data_valid}, 32'd0);
        check("rst_error", {30'd0, err_m, err_l}, 32'd0);
        check("rst_word_count", {24'd0, cnt_m}, 32'd0);
        check("rst_word_ready", {30'd0, bus_m.word_ready, bus_l.word_ready}, 32'd0);
        #21 reset = 1'b1;
        @(posedge clk); #1;

        // Table: clean word, sof mid-word, stray byte in IDLE, clean word.
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].done) begin
                q_m.push_back(tbl[i].w_msb);
                q_l.push_back(tbl[i].w_lsb);
            end
            send(tbl[i].b, tbl[i].sof);
            check($sformatf("err_m_v%0d", i), {31'd0, err_m}, {31'd0, tbl[i].err_next});
            check($sformatf("err_l_v%0d", i), {31'd0, err_l}, {31'd0, tbl[i].err_next});
            if (tbl[i].done)
                check($sformatf("valid_v%0d", i), {30'd0, bus_m.data_valid, bus_l.data_valid}, 32'd3);
        end
        check("cnt_m_after_table", {24'd0, cnt_m}, 32'd3);
        check("cnt_l_after_table", {30'd0, cnt_l}, 32'd3);
        idle_cycles(2);
        check("error_idle", {30'd0, err_m, err_l}, 32'd0);

        // Back-pressure: hold word 1, stall the closing byte of word 2.
        set_ready(1'b0);
        q_m.push_back(32'h10203040); q_l.push_back(32'h40302010);
        q_m.push_back(32'h50607080); q_l.push_back(32'h80706050);
        send(8'h10, 1'b1); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
        send(8'h50, 1'b1); send(8'h60, 1'b0); send(8'h70, 1'b0);
        drive(8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_word_ready", {30'd0, bus_m.word_ready, bus_l.word_ready}, 32'd0);
            check("stall_held_word", bus_m.data_out, 32'h10203040);
            @(posedge clk); #1;
        end
        set_ready(1'b1);
        wait_accept();
        check("b2b_valid", {30'd0, bus_m.data_valid, bus_l.data_valid}, 32'd3);
        check("cnt_m_after_bp", {24'd0, cnt_m}, 32'd5);
        check("cnt_l_wrap", {30'd0, cnt_l}, 32'd1);
        idle_cycles(3);

        // Reset mid-word discards the partial word.
        send(8'h0A, 1'b1); send(8'h0B, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_data_out", bus_m.data_out, 32'h0);
        check("mid_rst_outputs", {27'd0, bus_m.data_valid, err_m, err_l, bus_m.word_ready, bus_l.word_ready}, 32'd0);
        check("mid_rst_counts", {22'd0, cnt_m, cnt_l}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        q_m.push_back(32'hC1C2C3C4); q_l.push_back(32'hC4C3C2C1);
        send(8'hC1, 1'b1);
        check("post_rst_err0", {30'd0, err_m, err_l}, 32'd0);
        send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        check("post_rst_err3", {30'd0, err_m, err_l}, 32'd0);
        check("post_rst_cnt", {22'd0, cnt_m, cnt_l}, {22'd0, 8'd1, 2'd1});
        idle_cycles(3);
        check("q_m_drained", q_m.size(), 32'd0);
        check("q_l_drained", q_l.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/word_assembler.md
Name: word_assembler

Overview:
- Receive side of the 8-bit word bus.
- Accepts a byte stream on word_in, marked by a start-of-word flag, and reassembles 32-bit words on data_out.
- Flags framing violations on error and holds each completed word under a valid/ready handshake until the consumer takes it.
- Sits downstream of the word-bus producer; feeds the 32-bit datapath.

Parameters:
- MSB_FIRST, 1, 1: first byte of a word lands in data_out[31:24]; 0: first byte lands in data_out[7:0].
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- word_in  input  8  byte from word bus.
- word_valid  input  1  word_in holds a byte this cycle.
- word_sof  input  1  the byte on word_in is byte 0 of a word; qualified by word_valid.
- word_ready  output  1  block accepts a byte this cycle.
- data_out  output  32  assembled word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer takes data_out this cycle.
- error  output  1  one-cycle pulse on a framing violation.
- word_count  output  CNT_W  number of words delivered to data_out, modulo 2^CNT_W.

Behaviour:
- Reset low (async): state=IDLE, byte index=0, data_out=0, data_valid=0, error=0, word_count=0. word_ready is forced 0 while reset is low.
- Byte accepted = word_valid && word_ready at a rising edge.
- Output accepted = data_valid && data_ready at a rising edge.
- word_ready is combinational: 0 only when index==3 && data_valid && !data_ready; 1 otherwise.
  - No byte is ever lost.
  - Back-pressure occurs only on the 4th byte.
- FSM states: IDLE (index 0), COLLECT (index 1..3).
- IDLE:
  - Accepted byte with sof=1: stored as byte 0, index=1, go to COLLECT.
  - Accepted byte with sof=0: dropped, error=1 for the next cycle, stay in IDLE.
- COLLECT:
  - Accepted byte with sof=0: stored at position index, index++.
  - Accepted byte with sof=1: partial word discarded, error=1 for the next cycle, the new byte is stored as byte 0, index=1, stay in COLLECT.
  - 4th byte accepted (index==3, sof=0): assembled word loaded into data_out, data_valid=1, word_count++, index=0, go to IDLE. Latency is 1 cycle: data_valid is high in the cycle after the edge that accepts byte 3.
- Byte placement for byte k (k=0..3):
  - MSB_FIRST=1: data_out[31-8k -: 8].
  - MSB_FIRST=0: data_out[8k +: 8].
- Output register:
  - data_out and data_valid are held until output accepted.
  - On output accepted with no new load, data_valid=0; data_out keeps its last value.
  - Output accepted and a new load on the same edge: the new word is loaded and data_valid stays 1, giving back-to-back words with no bubble.
- word_valid=0 in COLLECT: hold state indefinitely; there is no timeout.
- word_count wraps from 2^CNT_W-1 to 0.
- error is registered, high for exactly one cycle per violation, and 0 otherwise.
- Reset asserted mid-word: the partial word and any pending data_out are discarded, with no error pulse.
- word_sof while word_valid=0 is ignored.

Decomposition:
- Shared package word_pkg holds:
  - state encoding (IDLE, COLLECT);
  - BYTES_PER_WORD=4 and BYTE_W=8;
  - index width 2.
- One sub-module, word_collector, is natural: it holds the byte index, the staging register, and the placement by MSB_FIRST, and outputs word_done plus the assembled word.
- The top level holds the FSM, the output register and handshake, the error logic, and the counter.

Test Plan:
- Bytes AA(sof),BB,CC,DD back-to-back with data_ready=1, MSB_FIRST=1 -> data_out=AABBCCDD, data_valid high 1 cycle after DD, word_count=1, error never high.
- Same stream with MSB_FIRST=0 -> data_out=DDCCBBAA.
- Bytes 11(sof),22,33(sof),44,55,66 -> error pulses 1 cycle after 33 is accepted; data_out=33445566; word_count=1.
- Byte 77 with sof=0 while in IDLE -> dropped, error pulses once, next word 01(sof),02,03,04 gives 01020304.
- data_ready=0, two words streamed -> first word held; word_ready drops while the 4th byte of the second word is presented. Raising data_ready delivers word1, then word2 on the next cycle with no loss.
- Reset pulsed low after 2 bytes of a word -> all outputs 0 immediately. A following full word assembles correctly with word_count=1 and no error.
